// File: rtl/i2c_apb_sequencer.sv
// APB master that turns one I2C job request plus TX/RX byte streams into the controller's register sequence.
// Optional poll timeout with abort is built when SEQ_TIMEOUT_EN is defined.
module i2c_apb_sequencer #(
    parameter int MAX_LEN    = 8,
    parameter int POLL_LIMIT = 1023
) (
    input  logic       PCLK,
    input  logic       PRESET,
    // valid/ready: a transfer happens on a rising edge where both are 1; ready never depends on valid
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [3:0] req_len,
    input  logic [7:0] req_prescale,
    input  logic       req_rstart,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       err,
    output logic       PSELx,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        IDLE, CFG, TXWAIT, PUSH, START, POLL, POP, RDDATA, FIN, ABORT
    } state_t;

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 15 || POLL_LIMIT < 1) begin : g_param_check
        $error("i2c_apb_sequencer: MAX_LEN must be 1..15 and POLL_LIMIT at least 1");
    end

    state_t     state, state_n;
    logic [1:0] step, step_n;
    logic       pen_n;
    logic       job_rw, job_rstart;
    logic [6:0] job_addr;
    logic [7:0] job_prescale, tx_byte, rs;
    logic [3:0] cnt, len_clamped;
    logic       xfer_done, accept, tx_hs, last_byte, poll_exit, poll_expire;

    assign rs          = {4'b0000, job_rstart, 3'b000};
    assign len_clamped = (req_len == 4'd0) ? 4'd1 : ((req_len > MAX_LEN_L) ? MAX_LEN_L : req_len);
    assign req_ready   = (state == IDLE);
    assign tx_ready    = (state == TXWAIT);
    assign PSELx       = (state != IDLE) && (state != TXWAIT);
    assign xfer_done   = PSELx && PENABLE && PREADY;
    assign accept      = req_valid && req_ready;
    assign tx_hs       = tx_valid && tx_ready;
    assign last_byte   = (cnt == 4'd1);
    // Read jobs wait for data in the RX FIFO, write jobs wait for the TX FIFO to drain.
    assign poll_exit   = job_rw ? ~PRDATA[4] : PRDATA[6];
    assign state_dbg   = state;

    always_comb begin
        state_n = state;
        step_n  = step;
        pen_n   = PSELx && !(PENABLE && PREADY);
        PADDR   = 8'h00;
        PWDATA  = 8'h00;
        PWRITE  = 1'b0;
        case (state)
            CFG: begin
                PWRITE = 1'b1;
                case (step)
                    2'd0:    begin PADDR = 8'h00; PWDATA = job_prescale; end
                    2'd1:    begin PADDR = 8'h14; PWDATA = {job_addr, job_rw}; end
                    default: begin PADDR = 8'h04; PWDATA = 8'h10 | rs; end
                endcase
            end
            PUSH: begin
                PWRITE = 1'b1;
                case (step)
                    2'd0:    begin PADDR = 8'h0C; PWDATA = tx_byte; end
                    2'd1:    begin PADDR = 8'h04; PWDATA = 8'h50 | rs; end
                    default: begin PADDR = 8'h04; PWDATA = 8'h10 | rs; end
                endcase
            end
            START:  begin PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 8'h90 | rs; end
            POLL:   PADDR = 8'h08;
            POP: begin
                PWRITE = 1'b1;
                PADDR  = 8'h04;
                PWDATA = (step == 2'd0) ? (8'hB0 | rs) : (8'h90 | rs);
            end
            RDDATA: PADDR = 8'h10;
            FIN:    begin PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 8'h10; end
            ABORT:  begin PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 8'h00; end
            default: ;
        endcase

        case (state)
            IDLE:   if (req_valid) begin state_n = CFG;  step_n = 2'd0; end
            TXWAIT: if (tx_valid)  begin state_n = PUSH; step_n = 2'd0; end
            default: if (xfer_done) begin
                step_n = step + 2'd1;
                case (state)
                    CFG: if (step == 2'd2) begin
                        step_n  = 2'd0;
                        state_n = job_rw ? START : TXWAIT;
                    end
                    PUSH: if (step == 2'd2) begin
                        step_n  = 2'd0;
                        state_n = last_byte ? START : TXWAIT;
                    end
                    START: begin step_n = 2'd0; state_n = POLL; end
                    POLL: begin
                        step_n = 2'd0;
                        if (poll_exit)        state_n = job_rw ? POP : FIN;
                        else if (poll_expire) state_n = ABORT;
                    end
                    POP: if (step == 2'd1) begin step_n = 2'd0; state_n = RDDATA; end
                    RDDATA: begin step_n = 2'd0; state_n = last_byte ? FIN : POLL; end
                    default: begin step_n = 2'd0; state_n = IDLE; end
                endcase
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            step    <= 2'd0;
            PENABLE <= 1'b0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            PENABLE <= pen_n;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            job_rw       <= 1'b0;
            job_rstart   <= 1'b0;
            job_addr     <= 7'd0;
            job_prescale <= 8'd0;
            cnt          <= 4'd0;
            tx_byte      <= 8'd0;
            rx_data      <= 8'd0;
            rx_valid     <= 1'b0;
            done         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                job_rw       <= req_rw;
                job_rstart   <= req_rstart;
                job_addr     <= req_addr;
                job_prescale <= req_prescale;
                cnt          <= len_clamped;
            end
            if (tx_hs) tx_byte <= tx_data;
            if (xfer_done) begin
                case (state)
                    PUSH: if (step == 2'd2 && !last_byte) cnt <= cnt - 4'd1;
                    RDDATA: begin
                        rx_data  <= PRDATA;
                        rx_valid <= 1'b1;
                        if (!last_byte) cnt <= cnt - 4'd1;
                    end
                    FIN, ABORT: done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0] poll_cnt;
    logic          err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= xfer_done && (state == ABORT);
            if (state_n == POLL && state != POLL)       poll_cnt <= '0;
            else if (xfer_done && state == POLL)        poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign poll_expire = (poll_cnt == PW'(POLL_LIMIT - 1));
    assign err         = err_q;
`else
    assign poll_expire = 1'b0;
    assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Directed bench for i2c_apb_sequencer: APB slave model with wait states, expected APB/RX queues.
module tb_i2c_apb_sequencer;
  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       req_valid = 1'b0, req_rw = 1'b0, req_rstart = 1'b0;
  logic [6:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic [7:0] req_prescale = '0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0;
  logic       req_ready, tx_ready, rx_valid, done, err, PSELx, PENABLE, PWRITE;
  logic [7:0] rx_data, PADDR, PWDATA;
  logic [3:0] state_dbg;

  i2c_apb_sequencer #(.MAX_LEN(8), .POLL_LIMIT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_len(req_len), .req_prescale(req_prescale), .req_rstart(req_rstart),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .err(err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  int         vec_count = 0, miss_count = 0;
  logic [16:0] exp_q[$];
  logic [7:0] rx_exp_q[$], rx_src_q[$], tx_q[$];
  int         wait_cfg = 0, poll_need = 2, poll_seen = 0, en_cycles = 0;
  int         done_cnt = 0, job_start = 0;
  bit         job_is_read = 0, exp_err = 0, tx_en = 1, tx_hs = 0;
  bit         prev_rx_cpl = 0, prev_end_cpl = 0;
  logic       su_w;
  logic [7:0] su_a, su_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ew(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic er(input logic [7:0] a);
    exp_q.push_back({1'b0, a, 8'h00});
  endtask

  task automatic model_read(input logic [7:0] a, output logic [7:0] d);
    bit rdy;
    d = 8'h00;
    if (a == 8'h08) begin
      poll_seen++;
      rdy = (poll_seen >= poll_need);
      if (rdy) poll_seen = 0;
      d = job_is_read ? {1'b0, 1'b1, 1'b0, ~rdy, 4'h0} : {1'b0, rdy, 1'b0, 1'b1, 4'h0};
    end else if (a == 8'h10) begin
      d = (rx_src_q.size() > 0) ? rx_src_q.pop_front() : 8'hEE;
    end
  endtask

  // TX stream driver: handshake seen at one negedge is consumed at the next
  always @(negedge PCLK) begin
    if (tx_hs && tx_q.size() > 0) void'(tx_q.pop_front());
    tx_valid = tx_en && (tx_q.size() > 0);
    tx_data  = tx_valid ? tx_q[0] : 8'h00;
    tx_hs    = tx_valid && tx_ready;
  end

  // APB slave model and scoreboard
  always @(negedge PCLK) begin
    logic [16:0] got;
    logic [7:0]  rd;
    if (PRESET) begin
      prev_rx_cpl  = 0;
      prev_end_cpl = 0;
    end else begin
      if (rx_valid || prev_rx_cpl) begin
        check("rx_valid_pulse", rx_valid, prev_rx_cpl);
        if (rx_valid) begin
          if (rx_exp_q.size() == 0) check("rx_unexpected", 1, 0);
          else check("rx_data", rx_data, rx_exp_q.pop_front());
        end
      end
      if (done || prev_end_cpl) begin
        check("done_pulse", done, prev_end_cpl);
        if (done) begin
          check("err", err, exp_err);
          done_cnt++;
        end
      end
      prev_rx_cpl  = 0;
      prev_end_cpl = 0;
      if (PENABLE && !PSELx) check("penable_without_psel", 0, 1);
      if (PSELx && !PENABLE) begin
        su_w = PWRITE; su_a = PADDR; su_d = PWDATA;
        en_cycles = 0;
        PREADY = (wait_cfg == 0);
        if (!PWRITE) begin
          model_read(PADDR, rd);
          PRDATA = rd;
        end
      end else if (PSELx && PENABLE) begin
        en_cycles++;
        if ({PWRITE, PADDR, PWDATA} !== {su_w, su_a, su_d})
          check("apb_stable", {PWRITE, PADDR, PWDATA}, {su_w, su_a, su_d});
        PREADY = (en_cycles > wait_cfg);
        if (PREADY) begin
          check("penable_len", en_cycles, wait_cfg + 1);
          got = {PWRITE, PADDR, PWRITE ? PWDATA : 8'h00};
          if (exp_q.size() == 0) check("apb_extra", got, 32'hFFFF_FFFF);
          else check("apb_seq", got, exp_q.pop_front());
          prev_rx_cpl  = !PWRITE && (PADDR == 8'h10);
          prev_end_cpl = (exp_q.size() == 0);
        end
      end
    end
  end

  task automatic step_cyc();
    @(negedge PCLK);
    #1;
  endtask

  task automatic start_job(input bit rw, input logic [6:0] addr, input logic [3:0] len,
                           input logic [7:0] presc, input bit rs);
    job_is_read = rw;
    poll_seen   = 0;
    job_start   = done_cnt;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_rw = rw; req_addr = addr; req_len = len;
    req_prescale = presc; req_rstart = rs;
    step_cyc();
    req_valid = 0;
    check("req_ready_busy", req_ready, 0);
  endtask

  task automatic finish_job(input int budget);
    for (int i = 0; i < budget && done_cnt == job_start; i++) step_cyc();
    check("done_count", done_cnt - job_start, 1);
    check("apb_left", exp_q.size(), 0);
    check("rx_left", rx_exp_q.size(), 0);
    check("tx_left", tx_q.size(), 0);
    step_cyc();
  endtask

  task automatic load_write_job_50();
    tx_q = '{8'hA5, 8'h3C};
    ew(8'h00, 8'h04); ew(8'h14, 8'hA0); ew(8'h04, 8'h10);
    ew(8'h0C, 8'hA5); ew(8'h04, 8'h50); ew(8'h04, 8'h10);
    ew(8'h0C, 8'h3C); ew(8'h04, 8'h50); ew(8'h04, 8'h10);
    ew(8'h04, 8'h90); er(8'h08); er(8'h08); ew(8'h04, 8'h10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) step_cyc();
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_state", state_dbg, 0);
    PRESET = 0;
    step_cyc();

    // write job, zero wait states
    load_write_job_50();
    start_job(0, 7'h50, 4'd2, 8'h04, 0);
    finish_job(500);

    // read job of three bytes
    rx_src_q = '{8'h11, 8'h22, 8'h33};
    rx_exp_q = '{8'h11, 8'h22, 8'h33};
    ew(8'h00, 8'h10); ew(8'h14, 8'h4F); ew(8'h04, 8'h10); ew(8'h04, 8'h90);
    for (int b = 0; b < 3; b++) begin
      er(8'h08); er(8'h08); ew(8'h04, 8'hB0); ew(8'h04, 8'h90); er(8'h10);
    end
    ew(8'h04, 8'h10);
    start_job(1, 7'h27, 4'd3, 8'h10, 0);
    finish_job(500);

    // five wait states on every access
    wait_cfg = 5;
    tx_q = '{8'h5A, 8'hC3};
    ew(8'h00, 8'h20); ew(8'h14, 8'h24); ew(8'h04, 8'h10);
    ew(8'h0C, 8'h5A); ew(8'h04, 8'h50); ew(8'h04, 8'h10);
    ew(8'h0C, 8'hC3); ew(8'h04, 8'h50); ew(8'h04, 8'h10);
    ew(8'h04, 8'h90); er(8'h08); er(8'h08); ew(8'h04, 8'h10);
    start_job(0, 7'h12, 4'd2, 8'h20, 0);
    finish_job(2000);
    wait_cfg = 0;

    // repeated start, TX stream stalled for a while
    tx_en = 0;
    tx_q = '{8'h77};
    ew(8'h00, 8'h80); ew(8'h14, 8'h74); ew(8'h04, 8'h18);
    ew(8'h0C, 8'h77); ew(8'h04, 8'h58); ew(8'h04, 8'h18);
    ew(8'h04, 8'h98); er(8'h08); er(8'h08); ew(8'h04, 8'h10);
    start_job(0, 7'h3A, 4'd1, 8'h80, 1);
    repeat (20) step_cyc();
    check("stall_tx_ready", tx_ready, 1);
    check("stall_psel", PSELx, 0);
    check("stall_state", state_dbg, 2);
    tx_en = 1;
    finish_job(500);

    // length 0 read with repeated start: one byte
    rx_src_q = '{8'h5C};
    rx_exp_q = '{8'h5C};
    ew(8'h00, 8'h01); ew(8'h14, 8'h03); ew(8'h04, 8'h18); ew(8'h04, 8'h98);
    er(8'h08); er(8'h08); ew(8'h04, 8'hB8); ew(8'h04, 8'h98); er(8'h10);
    ew(8'h04, 8'h10);
    start_job(1, 7'h01, 4'd0, 8'h01, 1);
    finish_job(500);

    // length 12 clamps to 8 bytes
    ew(8'h00, 8'h02); ew(8'h14, 8'hC2); ew(8'h04, 8'h10);
    for (int b = 1; b <= 8; b++) begin
      tx_q.push_back(8'(b * 17));
      ew(8'h0C, 8'(b * 17)); ew(8'h04, 8'h50); ew(8'h04, 8'h10);
    end
    ew(8'h04, 8'h90); er(8'h08); er(8'h08); ew(8'h04, 8'h10);
    start_job(0, 7'h61, 4'd12, 8'h02, 0);
    finish_job(1000);

`ifdef SEQ_TIMEOUT_EN
    // status never reports TX empty: four reads then abort
    poll_need = 1000;
    exp_err = 1;
    tx_q = '{8'h99};
    ew(8'h00, 8'h04); ew(8'h14, 8'hA0); ew(8'h04, 8'h10);
    ew(8'h0C, 8'h99); ew(8'h04, 8'h50); ew(8'h04, 8'h10); ew(8'h04, 8'h90);
    er(8'h08); er(8'h08); er(8'h08); er(8'h08); ew(8'h04, 8'h00);
    start_job(0, 7'h50, 4'd1, 8'h04, 0);
    finish_job(500);
    exp_err = 0;
    poll_need = 2;
`endif

    // reset during the ACCESS phase of a transmit write
    wait_cfg = 3;
    load_write_job_50();
    start_job(0, 7'h50, 4'd2, 8'h04, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step_cyc();
      found = PSELx && PENABLE && (PADDR == 8'h0C);
    end
    check("reach_tx_access", found, 1);
    PRESET = 1;
    step_cyc();
    check("rst_mid_psel", PSELx, 0);
    check("rst_mid_penable", PENABLE, 0);
    check("rst_mid_req_ready", req_ready, 1);
    PRESET = 0;
    exp_q.delete();
    tx_q.delete();
    wait_cfg = 0;
    step_cyc();
    check("rst_mid_no_done", done_cnt - job_start, 0);

    load_write_job_50();
    start_job(0, 7'h50, 4'd2, 8'h04, 0);
    finish_job(500);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule

// File: doc/i2c_apb_sequencer.md
# i2c_apb_sequencer

APB master that sits directly upstream of the I2C-APB top level and drives its APB slave port. It turns one high-level I2C job (slave address, direction, length, prescale) plus a byte stream into the exact APB register writes, pushes, polls and pops the controller needs. TX bytes come in and RX bytes go out on valid/ready streams. It runs on the APB clock, so a CPU or test harness never touches the register map directly.

## Interface
- `MAX_LEN`, default 8: maximum bytes per job; equals the controller FIFO depth.
- `POLL_LIMIT`, default 1023: maximum status reads per wait before timeout; used only with `SEQ_TIMEOUT_EN`.
- `PCLK` in 1: clock, shared with the controller APB side.
- `PRESET` in 1: synchronous, active-high reset.
- `req_valid` in 1: job request valid.
- `req_ready` out 1: idle and able to accept a job.
- `req_rw` in 1: 0 = I2C write, 1 = I2C read.
- `req_addr` in 7: 7-bit slave address.
- `req_len` in 4: byte count, 1..`MAX_LEN`.
- `req_prescale` in 8: SCL prescale value.
- `req_rstart` in 1: set `command[3]` (repeated start) for this job.
- `tx_valid` / `tx_ready` in/out 1: TX byte handshake.
- `tx_data` in 8: TX byte.
- `rx_valid` out 1: one-cycle pulse carrying an RX byte.
- `rx_data` out 8: RX byte.
- `done` out 1: one-cycle job-complete pulse.
- `err` out 1: valid with `done`; 1 = timeout abort.
- `PSELx`, `PENABLE`, `PWRITE` out 1: APB master controls.
- `PADDR` out 8: APB address.
- `PWDATA` out 8: APB write data.
- `PRDATA` in 8: APB read data.
- `PREADY` in 1: APB ready.

## Operation
- Register map:
  - 0x00 prescale
  - 0x04 command: [7] enable, [6] TX push, [5] RX pop, [4] core reset_n, [3] repeated start
  - 0x08 status: [7] TX full, [6] TX empty, [5] RX full, [4] RX empty
  - 0x0C transmit
  - 0x10 receive
  - 0x14 address
- Job accepted when `req_valid & req_ready`. All `req_*` fields are latched at acceptance.
- `req_len` of 0 is treated as 1. Values above `MAX_LEN` are clamped to `MAX_LEN`.
- `R` below is `req_rstart`<<3, taken from the latched value.
- Job sequence, every step one APB transfer:
  - CFG: W 0x00 = prescale; W 0x14 = {addr, rw}; W 0x04 = 0x10 | R.
  - Write job, per byte:
    - TXWAIT: assert `tx_ready` until a handshake.
    - W 0x0C = byte.
    - W 0x04 = 0x50 | R (push).
    - W 0x04 = 0x10 | R.
  - Write job, after the last byte: W 0x04 = 0x90 | R (start), then POLL: R 0x08 repeatedly until `PRDATA[6]` = 1 (TX empty).
  - Read job: W 0x04 = 0x90 | R, then per byte:
    - POLL: R 0x08 until `PRDATA[4]` = 0.
    - W 0x04 = 0xB0 | R (pop).
    - W 0x04 = 0x90 | R.
    - R 0x10; capture `PRDATA` into `rx_data` and pulse `rx_valid`.
  - FIN: W 0x04 = 0x10 (enable off), pulse `done`, return to IDLE.
- States: IDLE, CFG, TXWAIT, PUSH, START, POLL, POP, RDDATA, FIN, ABORT.
- Byte counter counts down from the latched length. The last byte is detected at count 1; there is no wrap.
- `rx_valid` has no backpressure. The consumer must accept every byte.

## Timing
- APB master: SETUP cycle (`PSELx`=1, `PENABLE`=0), then ACCESS cycle (`PENABLE`=1), held until `PREADY`=1.
- Address, data and `PWRITE` are stable across SETUP and ACCESS.
- Minimum 2 cycles per transfer. Transfers are back-to-back with no idle cycle in between.
- Read data is sampled on the ACCESS cycle where `PREADY`=1.
- `rx_valid` is asserted on the cycle after the receive read completes.
- `done` is asserted on the cycle after the FIN write completes.
- `req_ready` = 1 only in IDLE. A new request can be accepted the cycle after `done`.
- Reset values:
  - `PSELx`, `PENABLE`, `PWRITE`, `rx_valid`, `done`, `err`, `tx_ready`: 0
  - `PADDR`, `PWDATA`, `rx_data`: 0
  - `req_ready`: 1
  - state: IDLE
- `PRESET` mid-transfer drops `PSELx`/`PENABLE` on the next edge and abandons the job. No FIN write is issued.
- `tx_valid` held low stalls in TXWAIT indefinitely; there is no timeout there.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - Each POLL wait counts status reads.
  - After `POLL_LIMIT` reads without the exit condition, go to ABORT: W 0x04 = 0x00 (reset core and FIFOs), then pulse `done` with `err`=1.
  - The poll counter clears on entry to every POLL.
- `SEQ_TIMEOUT_EN` undefined: POLL waits forever, `err` is tied to 0, and the counter logic is absent.

## Test plan
- Write job, addr 0x50, len 2, data 0xA5,0x3C, prescale 0x04, PREADY always 1 -> APB writes in exact order: 0x00←04, 0x14←A0, 0x04←10, 0x0C←A5, 0x04←50, 0x04←10, 0x0C←3C, 0x04←50, 0x04←10, 0x04←90, status polls, 0x04←10; then `done`=1, `err`=0.
- Read job, addr 0x27, len 3; slave model returns receive 0x11,0x22,0x33 after status[4] falls -> three `rx_valid` pulses with exactly those bytes; address write = 0x4F.
- PREADY held low 5 cycles on each access -> `PENABLE` held 6 cycles per transfer; addr/data stable; same final result.
- `req_rstart`=1 -> every command write has bit3 set except FIN (0x10).
- With `SEQ_TIMEOUT_EN`, `POLL_LIMIT`=4, status TX empty never set -> exactly 4 status reads, W 0x04←00, `done` with `err`=1.
- `PRESET` asserted during ACCESS of a transmit write -> next cycle `PSELx`=0, `req_ready`=1; a new job then runs cleanly.
